// File: rtl/serial_rx_if.sv
// Serial receiver port bundle: line input plus received word and status pulses.
// master = line driver / word consumer, slave = receiver.
interface serial_rx_if #(
    parameter int SIZE = 8
);
    logic            SerIn;
    logic [SIZE-1:0] DataOut;
    logic            Valid;
    logic            FrameErr;
    logic            ParErr;
    logic            Busy;

    modport master (
        output SerIn,
        input  DataOut, Valid, FrameErr, ParErr, Busy
    );

    modport slave (
        input  SerIn,
        output DataOut, Valid, FrameErr, ParErr, Busy
    );
endinterface

// File: rtl/serial_rx.sv
// Oversampling serial receiver: start, SIZE data bits MSB first, stop.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_rx #(
    parameter int SIZE = 8,
    parameter int DIV  = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    serial_rx_if.slave  bus
);
    localparam int CW = $clog2(DIV);
    localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, s_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [SIZE-1:0] shift_q, shift_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            s;
`ifdef SERIAL_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            perr_q, perr_d;
`endif

    assign s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s_prev_q && !s) begin
                    state_d = ST_START;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = SIZE'({shift_q, s});
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, s};
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    // A low stop bit outranks a parity mismatch.
                    if (!s) begin
                        ferr_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            s_prev_q <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= bus.SerIn;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.DataOut  = data_q;
    assign bus.Valid    = valid_q;
    assign bus.FrameErr = ferr_q;
    assign bus.Busy     = busy_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.ParErr   = perr_q;
`else
    assign bus.ParErr   = 1'b0;
`endif
endmodule
